mul_div_ctrl: RTL and testbench
===============================

MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 Port reset, input, 1: synchronous, active-high reset.
REQ-003 Port start, input, 1: EX stage presents a multiply/divide instruction this cycle.
REQ-004 Port funct, input, 6: instruction funct field; 011000 mult, 011001 multu, 011010 div, 011011 divu.
REQ-005 Port a, input, 32: rs operand (multiplicand/dividend).
REQ-006 Port b, input, 32: rt operand (multiplier/divisor).
REQ-007 Port rd_hilo, input, 1: EX stage is executing mfhi/mflo this cycle.
REQ-008 Port busy, output, 1: operation in progress.
REQ-009 Port stall, output, 1: freeze PC and pipeline registers.
REQ-010 Port done, output, 1: one-cycle pulse; result committed to hi/lo.
REQ-011 Port hi, output, 32: HI register (product upper half / remainder).
REQ-012 Port lo, output, 32: LO register (product lower half / quotient).

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX; busy SHALL equal (state != IDLE).
REQ-014 IDLE: start=1 with a valid funct SHALL latch a, b, op, set cnt=0, enter CALC; an invalid funct SHALL be ignored (stay IDLE, no hi/lo change).
REQ-015 start SHALL be ignored while busy=1; no queueing.
REQ-016 CALC SHALL run exactly 32 cycles (cnt 0..31), one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; cnt=31 SHALL transition to FIX.
REQ-017 Signed ops (mult, div) SHALL iterate on operand magnitudes; unsigned ops SHALL iterate on raw operands.
REQ-018 FIX (1 cycle): signed multiply SHALL negate the 64-bit product if operand signs differ; signed divide SHALL negate the quotient if signs differ and the remainder if the dividend is negative; the result SHALL then be written to hi/lo and the FSM SHALL return to IDLE.
REQ-019 done SHALL be 1 in the single cycle after FIX, with hi/lo already holding the new result; otherwise 0.
REQ-020 Latency: start sampled at edge N -> busy high for cycles N+1..N+33, done and new hi/lo visible in cycle N+34.
REQ-021 hi/lo SHALL change only at the FIX->IDLE edge or on reset; they SHALL hold the old value throughout CALC/FIX.
REQ-022 stall SHALL be combinational: (busy & rd_hilo) | (busy & start).
REQ-023 Divide by zero SHALL still take the full latency and yield hi=dividend (as given, sign unchanged), lo=0xFFFFFFFF.
REQ-024 div 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (32-bit wrap, no exception).
REQ-025 mult 0x80000000 * 0x80000000 SHALL yield hi=0x40000000, lo=0.

Reset
REQ-026 reset=1 SHALL, at the next edge, force state=IDLE, cnt=0, hi=0, lo=0, done=0, regardless of state; an in-flight operation SHALL be discarded with no partial result visible.
REQ-027 reset SHALL take priority over start in the same cycle.
REQ-028 After reset, busy=0 and stall=0 in the cycle following the reset edge.

Structure
REQ-029 funct codes (MULT, MULTU, DIV, DIVU, MFHI, MFLO) and the FSM state encoding SHALL live in the shared CPU definitions package (mips_defs_pkg), with the ALU control constants.
REQ-030 The block SHALL be one module with no sub-modules; magnitude/negate helpers SHALL be local functions.
REQ-031 The iteration datapath SHALL use one 64-bit accumulator/remainder-quotient shift register, one 32-bit operand register, and one 32-bit adder/subtractor shared by multiply and divide.

Verification
REQ-032 multu a=0xFFFFFFFF b=0xFFFFFFFF -> done at cycle N+34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 mult a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-034 div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=100 b=0 -> hi=0x64, lo=0xFFFFFFFF.
REQ-035 rd_hilo=1 at cycle N+5 of a busy op -> stall=1 until done; second start at N+10 ignored, hi/lo reflect the first op only.
REQ-036 reset asserted at cycle N+16 of a divide -> next cycle busy=0, hi=lo=0, done never pulses for that op.
REQ-037 div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; mult 0x80000000*0x80000000 -> hi=0x40000000, lo=0.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared CPU definitions: funct codes, ALU control constants and the
// multiply/divide controller state encoding.
package mips_defs_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    function automatic logic is_muldiv_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_ctrl_if.sv
// EX-stage <-> multiply/divide unit signal bundle; the CPU side is the
// master, the unit is the slave.
interface mul_div_ctrl_if;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hilo;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, funct, a, b, rd_hilo,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, funct, a, b, rd_hilo,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/mul_div_ctrl.sv
// Iterative 32x32 multiply / 32/32 divide unit owning HI/LO: 32 radix-2
// steps on magnitudes through one shared adder, then a sign fix-up cycle.
module mul_div_ctrl
    import mips_defs_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mul_div_ctrl_if.slave  md
);

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

    md_state_e   state_q, state_d;
    logic        launch;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic        is_div_q;
    logic        neg_q_q;
    logic        neg_r_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        op_signed, op_div;
    logic [31:0] a_in, b_in;
    logic [32:0] alu_lhs, alu_rhs_x;
    logic [31:0] alu_rhs;
    logic [33:0] alu_sum;
    logic [63:0] acc_step;
    logic [63:0] result;

    assign op_signed = (md.funct == FUNCT_MULT) || (md.funct == FUNCT_DIV);
    assign op_div    = (md.funct == FUNCT_DIV)  || (md.funct == FUNCT_DIVU);
    assign a_in      = op_signed ? mag32(md.a) : md.a;
    assign b_in      = op_signed ? mag32(md.b) : md.b;

    always_ff @(posedge clk) begin
        if (reset) state_q <= MD_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            MD_IDLE: if (md.start && is_muldiv_funct(md.funct)) begin
                state_d = MD_CALC;
                launch  = 1'b1;
            end
            MD_CALC: if (cnt_q == 5'd31) state_d = MD_FIX;
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // One adder: multiply adds the operand into the upper half when the
    // LSB is set; divide subtracts it from the 33-bit shifted remainder.
    assign alu_rhs   = (is_div_q || acc_q[0]) ? opnd_q : 32'd0;
    assign alu_lhs   = is_div_q ? acc_q[63:31] : {1'b0, acc_q[63:32]};
    assign alu_rhs_x = is_div_q ? ~{1'b0, alu_rhs} : {1'b0, alu_rhs};
    assign alu_sum   = {1'b0, alu_lhs} + {1'b0, alu_rhs_x} + {33'd0, is_div_q};

    always_comb begin
        acc_step = {alu_sum[32:0], acc_q[31:1]};
        if (is_div_q) begin
            acc_step = alu_sum[33] ? {alu_sum[31:0], acc_q[30:0], 1'b1}
                                   : {acc_q[62:0], 1'b0};
        end
    end

    // A zero divisor keeps the all-ones quotient unsigned-looking even for div.
    always_comb begin
        result = neg_q_q ? neg64(acc_q) : acc_q;
        if (is_div_q) begin
            result[31:0]  = (neg_q_q && (opnd_q != 32'd0)) ? neg32(acc_q[31:0]) : acc_q[31:0];
            result[63:32] = neg_r_q ? neg32(acc_q[63:32]) : acc_q[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (launch) begin
                cnt_q    <= 5'd0;
                acc_q    <= {32'd0, op_div ? a_in : b_in};
                opnd_q   <= op_div ? b_in : a_in;
                is_div_q <= op_div;
                neg_q_q  <= op_signed & (md.a[31] ^ md.b[31]);
                neg_r_q  <= op_signed & op_div & md.a[31];
            end else if (state_q == MD_CALC) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + 5'd1;
            end else if (state_q == MD_FIX) begin
                hi_q   <= result[63:32];
                lo_q   <= result[31:0];
                done_q <= 1'b1;
                cnt_q  <= 5'd0;
            end
        end
    end

    assign md.busy  = (state_q != MD_IDLE);
    assign md.stall = (md.busy & md.rd_hilo) | (md.busy & md.start);
    assign md.done  = done_q;
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Randomized and directed checks of mul_div_ctrl against a plain-arithmetic
// HI/LO model.
module tb_mul_div_ctrl;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [63:0] exp_hilo;

    mul_div_ctrl_if md_if();

    mul_div_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] ea, eb;
        int sa, sb;
        case (f)
            FN_MULTU: return {32'd0, a} * {32'd0, b};
            FN_MULT: begin
                ea = {{32{a[31]}}, a};
                eb = {{32{b[31]}}, b};
                return ea * eb;
            end
            FN_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            FN_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                sa = a;
                sb = b;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int rd_at, input int restart_at);
        logic [63:0] exp;
        int cyc;
        exp = ref_md(f, a, b);
        md_if.start = 1'b1;
        md_if.funct = f;
        md_if.a     = a;
        md_if.b     = b;
        @(posedge clk); #1;
        md_if.start = 1'b0;
        cyc = 1;
        #1;
        check("busy_first", {63'd0, md_if.busy}, 64'd1);
        while (md_if.done !== 1'b1 && cyc < 40) begin
            if (cyc == rd_at) md_if.rd_hilo = 1'b1;
            if (cyc == restart_at) begin
                md_if.start = 1'b1;
                md_if.funct = FN_DIVU;
                md_if.a     = $urandom;
                md_if.b     = $urandom | 32'd1;
            end
            #1;
            if (rd_at > 0 && cyc >= rd_at) check("stall_rd", {63'd0, md_if.stall}, 64'd1);
            if (cyc == restart_at) check("stall_start", {63'd0, md_if.stall}, 64'd1);
            if (cyc == 33) begin
                check("busy_last", {63'd0, md_if.busy}, 64'd1);
                check("hold_hilo", {md_if.hi, md_if.lo}, exp_hilo);
            end
            @(posedge clk); #1;
            md_if.start = 1'b0;
            cyc++;
        end
        #1;
        check("latency", 64'(cyc), 64'd34);
        check("result", {md_if.hi, md_if.lo}, exp);
        check("busy_done", {63'd0, md_if.busy}, 64'd0);
        if (rd_at > 0) check("stall_done", {63'd0, md_if.stall}, 64'd0);
        md_if.rd_hilo = 1'b0;
        exp_hilo = exp;
        $display("op funct=%b a=%h b=%h -> hi=%h lo=%h (expect %h %h)",
                 f, a, b, md_if.hi, md_if.lo, exp[63:32], exp[31:0]);
        @(posedge clk); #1;
        check("done_pulse", {63'd0, md_if.done}, 64'd0);
        check("idle_after", {63'd0, md_if.busy}, 64'd0);
    endtask

    initial begin
        logic [5:0] fl [4];
        int cyc;
        int dcount;
        n_vec = 0;
        n_err = 0;
        exp_hilo = 64'd0;
        fl[0] = FN_MULT; fl[1] = FN_MULTU; fl[2] = FN_DIV; fl[3] = FN_DIVU;
        reset = 1'b1;
        md_if.start = 1'b0;
        md_if.funct = 6'd0;
        md_if.a = 32'd0;
        md_if.b = 32'd0;
        md_if.rd_hilo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_busy", {63'd0, md_if.busy}, 64'd0);
        check("rst_stall", {63'd0, md_if.stall}, 64'd0);
        check("rst_done", {63'd0, md_if.done}, 64'd0);
        check("rst_hilo", {md_if.hi, md_if.lo}, 64'd0);

        run_op(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        run_op(FN_MULT,  32'hFFFFFFFD, 32'd5, 0, 0);
        run_op(FN_DIV,   32'hFFFFFFF9, 32'd2, 0, 0);
        run_op(FN_DIVU,  32'd100, 32'd0, 0, 0);
        run_op(FN_DIV,   32'hFFFFFFF9, 32'd0, 0, 0);
        run_op(FN_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0);
        run_op(FN_MULT,  32'h80000000, 32'h80000000, 0, 0);
        run_op(FN_MULT,  32'h12345678, 32'hFEDCBA98, 5, 10);

        // Invalid funct is ignored and leaves HI/LO alone.
        md_if.start = 1'b1;
        md_if.funct = 6'b100000;
        md_if.a = $urandom;
        md_if.b = $urandom;
        @(posedge clk); #1;
        md_if.start = 1'b0;
        #1;
        check("bad_funct_busy", {63'd0, md_if.busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bad_funct_hilo", {md_if.hi, md_if.lo}, exp_hilo);

        for (int i = 0; i < 20; i++) begin
            run_op(fl[$urandom_range(0, 3)], pick_operand(), pick_operand(), 0, 0);
        end

        // Reset in the middle of a divide discards it.
        md_if.start = 1'b1;
        md_if.funct = FN_DIV;
        md_if.a = $urandom;
        md_if.b = 32'd7;
        @(posedge clk); #1;
        md_if.start = 1'b0;
        cyc = 1;
        while (cyc < 16) begin
            @(posedge clk); #1;
            cyc++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midrst_busy", {63'd0, md_if.busy}, 64'd0);
        check("midrst_stall", {63'd0, md_if.stall}, 64'd0);
        check("midrst_done", {63'd0, md_if.done}, 64'd0);
        check("midrst_hilo", {md_if.hi, md_if.lo}, 64'd0);
        exp_hilo = 64'd0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (md_if.done === 1'b1) dcount++;
        end
        check("midrst_no_done", 64'(dcount), 64'd0);
        $display("op reset at cycle 16 of div -> hi=%h lo=%h", md_if.hi, md_if.lo);

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        md_if.start = 1'b1;
        md_if.funct = FN_MULTU;
        md_if.a = 32'd3;
        md_if.b = 32'd4;
        @(posedge clk); #1;
        reset = 1'b0;
        md_if.start = 1'b0;
        #1;
        check("rst_prio_busy", {63'd0, md_if.busy}, 64'd0);
        $display("op reset+start same cycle -> busy=%b", md_if.busy);

        run_op(FN_DIVU, $urandom, $urandom_range(1, 1000), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
